// File: rtl/mem_rd_capture.sv
// Read-data capture FIFO: samples mem_data on every ds pulse, tags each word with
// the length of the preceding rd window, and presents entries over valid/ready.
module mem_rd_capture #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int LAT_W  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rd,
  input  logic                     ds,
  input  logic [DATA_W-1:0]        mem_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [LAT_W-1:0]         out_lat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     ovf,
  input  logic                     ovf_clr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = DATA_W + LAT_W;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [ENT_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic             ovf_q, ovf_d;

  logic pop;
  logic push_ok;

  assign empty     = (count_q == '0);
  assign full      = (count_q == DEPTH_C);
  assign count     = count_q;
  assign out_valid = !empty;
  assign ovf       = ovf_q;
  assign out_data  = mem_q[rd_ptr_q][ENT_W-1:LAT_W];
  assign out_lat   = mem_q[rd_ptr_q][LAT_W-1:0];

  // A push into a full FIFO still fits if the head leaves in the same cycle.
  assign pop     = out_valid && out_ready;
  assign push_ok = ds && (!full || pop);

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    lat_cnt_d = lat_cnt_q;
    ovf_d     = ovf_q;

    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;

    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (ds) begin
      lat_cnt_d = '0;
    end else if (rd) begin
      if (lat_cnt_q != '1) lat_cnt_d = lat_cnt_q + 1'b1;
    end else begin
      lat_cnt_d = '0;
    end

    // Setting wins over a coincident clear so a drop is never lost.
    if (ds && !push_ok) ovf_d = 1'b1;
    else if (ovf_clr)   ovf_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      lat_cnt_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      lat_cnt_q <= lat_cnt_d;
      ovf_q     <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= {mem_data, lat_cnt_q};
  end

endmodule
